// File: rtl/morra_scoreboard.sv
// morra_scoreboard
//   Tallies rounds, games and the match outcome reported by the MorraCinese
//   FSMD. A three-state FSM (IDLE, PLAY, HOLD) decides which FSMD results
//   count. All outputs are registered, so each one changes on the clock edge
//   after the inputs that cause it are sampled.
//
// Ports
//   clk           system clock; all state changes on its rising edge
//   RST           synchronous active-high reset
//   START         start strobe shared with the FSMD
//   ROUND[1:0]    round result: 00 none, 01 P1, 10 P2, 11 tie
//   GAME[1:0]     game result: 00 in progress, 01 P1, 10 P2, 11 tie
//   R1/R2/RT_CNT  round tallies for the current game (P1, P2, tie)
//   G1/G2/GT_CNT  game tallies for the current match (P1, P2, tie)
//   GAME_DONE     one-cycle pulse for every game that is counted
//   MATCH_OVER    high while the match is finished (HOLD)
//   MATCH_WINNER  01 P1, 10 P2, 00 none; valid while MATCH_OVER is high

module morra_scoreboard #(
    parameter int MATCH_WINS = 3,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       ROUND,
    input  logic [1:0]       GAME,
    output logic [CNT_W-1:0] R1_CNT,
    output logic [CNT_W-1:0] R2_CNT,
    output logic [CNT_W-1:0] RT_CNT,
    output logic [CNT_W-1:0] G1_CNT,
    output logic [CNT_W-1:0] G2_CNT,
    output logic [CNT_W-1:0] GT_CNT,
    output logic             GAME_DONE,
    output logic             MATCH_OVER,
    output logic [1:0]       MATCH_WINNER
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        HOLD = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] MATCH_TGT = CNT_W'(MATCH_WINS);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] r1_nxt, r2_nxt, rt_nxt;
    logic [CNT_W-1:0] g1_nxt, g2_nxt, gt_nxt;
    logic             game_done_nxt;
    logic             match_over_nxt;
    logic [1:0]       winner_nxt;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nxt      = state;
        r1_nxt         = R1_CNT;
        r2_nxt         = R2_CNT;
        rt_nxt         = RT_CNT;
        g1_nxt         = G1_CNT;
        g2_nxt         = G2_CNT;
        gt_nxt         = GT_CNT;
        game_done_nxt  = 1'b0;
        match_over_nxt = MATCH_OVER;
        winner_nxt     = MATCH_WINNER;

        unique case (state)
            IDLE: begin
                // Results from the FSMD are meaningless until a match starts.
                if (START) begin
                    state_nxt = PLAY;
                    r1_nxt    = CNT_ZERO;
                    r2_nxt    = CNT_ZERO;
                    rt_nxt    = CNT_ZERO;
                    g1_nxt    = CNT_ZERO;
                    g2_nxt    = CNT_ZERO;
                    gt_nxt    = CNT_ZERO;
                end
            end

            PLAY: begin
                if (START) begin
                    // A restart abandons the current game without counting it.
                    r1_nxt = CNT_ZERO;
                    r2_nxt = CNT_ZERO;
                    rt_nxt = CNT_ZERO;
                end else if (GAME != 2'b00) begin
                    // A finished game overrides any round result in the same cycle.
                    r1_nxt        = CNT_ZERO;
                    r2_nxt        = CNT_ZERO;
                    rt_nxt        = CNT_ZERO;
                    game_done_nxt = 1'b1;
                    case (GAME)
                        2'b01: begin
                            g1_nxt = sat_inc(G1_CNT);
                            if (g1_nxt == MATCH_TGT) begin
                                state_nxt      = HOLD;
                                match_over_nxt = 1'b1;
                                winner_nxt     = 2'b01;
                            end
                        end
                        2'b10: begin
                            g2_nxt = sat_inc(G2_CNT);
                            if (g2_nxt == MATCH_TGT) begin
                                state_nxt      = HOLD;
                                match_over_nxt = 1'b1;
                                winner_nxt     = 2'b10;
                            end
                        end
                        default: gt_nxt = sat_inc(GT_CNT); // ties never end the match
                    endcase
                end else begin
                    case (ROUND)
                        2'b01:   r1_nxt = sat_inc(R1_CNT);
                        2'b10:   r2_nxt = sat_inc(R2_CNT);
                        2'b11:   rt_nxt = sat_inc(RT_CNT);
                        default: ;
                    endcase
                end
            end

            HOLD: begin
                // Final score stays on display until a new match is started.
                if (START) begin
                    state_nxt      = PLAY;
                    r1_nxt         = CNT_ZERO;
                    r2_nxt         = CNT_ZERO;
                    rt_nxt         = CNT_ZERO;
                    g1_nxt         = CNT_ZERO;
                    g2_nxt         = CNT_ZERO;
                    gt_nxt         = CNT_ZERO;
                    match_over_nxt = 1'b0;
                    winner_nxt     = 2'b00;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (RST) begin
            state        <= IDLE;
            R1_CNT       <= CNT_ZERO;
            R2_CNT       <= CNT_ZERO;
            RT_CNT       <= CNT_ZERO;
            G1_CNT       <= CNT_ZERO;
            G2_CNT       <= CNT_ZERO;
            GT_CNT       <= CNT_ZERO;
            GAME_DONE    <= 1'b0;
            MATCH_OVER   <= 1'b0;
            MATCH_WINNER <= 2'b00;
        end else begin
            state        <= state_nxt;
            R1_CNT       <= r1_nxt;
            R2_CNT       <= r2_nxt;
            RT_CNT       <= rt_nxt;
            G1_CNT       <= g1_nxt;
            G2_CNT       <= g2_nxt;
            GT_CNT       <= gt_nxt;
            GAME_DONE    <= game_done_nxt;
            MATCH_OVER   <= match_over_nxt;
            MATCH_WINNER <= winner_nxt;
        end
    end

endmodule
